scrambler_par: RTL

SCRAMBLER_PAR -- requirements
Module: scrambler_par

---
 rtl/scrambler_par.sv | 85 ++++++++
 1 files changed

// File: rtl/scrambler_par.sv
// Parallel additive/multiplicative LFSR scrambler: STEPS Galois steps per accepted word,
// with a one-deep output register. Optional word counter port under SCRAMBLER_PAR_STATS_EN.
module scrambler_par #(
   parameter int              WIDTH = 32,
   parameter int              STEPS = 16,
   parameter logic [WIDTH-1:0] POLY = WIDTH'(32'h82F63B78)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic [STEPS-1:0] pad_key,
   output logic [WIDTH-1:0] dout,
   output logic             out_valid,
   input  logic             out_ready
`ifdef SCRAMBLER_PAR_STATS_EN
   ,
   output logic [31:0]      word_cnt
`endif
);

   logic [WIDTH-1:0] state_p0;
   logic [WIDTH-1:0] dout_p1;
   logic             vld_p1;
   logic             accept;
   logic             fire;
   logic [WIDTH-1:0] f_in;
   logic [WIDTH-1:0] f_out;

   // STEPS chained shift-in-key-bit steps, key bit 0 applied first.
   function automatic logic [WIDTH-1:0] lfsr_f(input logic [WIDTH-1:0] start,
                                               input logic [STEPS-1:0] key);
      logic [WIDTH-1:0] cur;
      cur = start;
      for (int i = 0; i < STEPS; i++) begin
         cur = {cur[WIDTH-2:0], key[i]} ^ (cur[WIDTH-1] ? POLY : '0);
      end
      return cur;
   endfunction

   assign in_ready  = !vld_p1 || out_ready;
   assign accept    = in_valid && in_ready;
   assign fire      = vld_p1 && out_ready;
   assign dout      = dout_p1;
   assign out_valid = vld_p1;

   // A seed strobe coinciding with a stream-mode word replaces the state for that word.
   assign f_in  = mode ? (seed_load ? seed : state_p0) : data_in;
   assign f_out = lfsr_f(f_in, pad_key);

   // Stage p0 -> p1: state update and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p0 <= '0;
         dout_p1  <= '0;
         vld_p1   <= 1'b0;
      end else if (accept) begin
         state_p0 <= f_out;
         dout_p1  <= mode ? (data_in ^ f_out) : f_out;
         vld_p1   <= 1'b1;
      end else begin
         if (seed_load) begin
            state_p0 <= seed;
         end
         if (fire) begin
            vld_p1 <= 1'b0;
         end
      end
   end

`ifdef SCRAMBLER_PAR_STATS_EN
   always_ff @(posedge clk) begin
      if (rst || seed_load) begin
         word_cnt <= '0;
      end else if (fire && (word_cnt != 32'hFFFF_FFFF)) begin
         word_cnt <= word_cnt + 32'd1;
      end
   end
`endif

endmodule
